// File: rtl/syn_toggle_tx.sv
// syn_toggle_tx: source side of a toggle-handshake clock-domain crossing.
// A word accepted on in_valid/in_ready is held on tx_data and announced by
// flipping req_tgl. The far side answers by flipping ack_tgl. That toggle is
// synchronized into slow_clk, and the transfer completes once it matches req_tgl.
// Optional feature: define SYN_TX_TIMEOUT_EN to add an ack timeout with
// err / err_flag outputs.
module syn_toggle_tx #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_tgl,
  output logic [DATA_W-1:0] tx_data,
  input  logic              ack_tgl,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_cnt
`ifdef SYN_TX_TIMEOUT_EN
  ,
  output logic              err,
  output logic              err_flag
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   ack_match;

  logic                   req_nxt;
  logic [DATA_W-1:0]      data_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic [CNT_W-1:0]       cnt_nxt;

`ifdef SYN_TX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0]       tmo_cnt;
  logic [TMO_W-1:0]       tmo_nxt;
  logic                   err_nxt;
`endif

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign ack_match = (ack_s == req_tgl);
  assign in_ready  = (state == IDLE) && ack_match;

  // Multi-flop synchronizer; ack_s is the only consumer of ack_tgl.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
    end
  end

  // State and output registers.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_nxt;
      req_tgl  <= req_nxt;
      tx_data  <= data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      xfer_cnt <= cnt_nxt;
    end
  end

`ifdef SYN_TX_TIMEOUT_EN
  // Timeout counter and error flags; err_flag is sticky until reset.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      err      <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      tmo_cnt  <= tmo_nxt;
      err      <= err_nxt;
      err_flag <= err_flag | err_nxt;
    end
  end
`endif

  // Next-state and next-output logic; data and toggle change only on accept.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_tgl;
    data_nxt  = tx_data;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    cnt_nxt   = xfer_cnt;
`ifdef SYN_TX_TIMEOUT_EN
    tmo_nxt   = tmo_cnt;
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_nxt  = in_data;
          req_nxt   = ~req_tgl;
          busy_nxt  = 1'b1;
          state_nxt = WAIT_ACK;
`ifdef SYN_TX_TIMEOUT_EN
          tmo_nxt   = TMO_W'(TIMEOUT_CYC);
`endif
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = xfer_cnt + CNT_W'(1);
          state_nxt = IDLE;
        end
`ifdef SYN_TX_TIMEOUT_EN
        // Give up on the ack; req_tgl/tx_data stay put so a late ack is absorbed in IDLE.
        else if (tmo_cnt <= TMO_W'(1)) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt   = tmo_cnt - TMO_W'(1);
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_syn_toggle_tx.sv
// Testbench for syn_toggle_tx: directed scenarios plus random traffic. A
// behavioural model predicts every output each cycle. A far-side receiver model
// captures the words and returns acknowledges after a delay.
module tb_syn_toggle_tx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 8;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       req_tgl;
  logic [3:0] tx_data;
  logic       ack_tgl;
  logic       busy;
  logic       done;
  logic [7:0] xfer_cnt;
`ifdef SYN_TX_TIMEOUT_EN
  logic       err;
  logic       err_flag;
`endif

  always #5 slow_clk = ~slow_clk;

  syn_toggle_tx #(
    .DATA_W(4), .SYNC_STAGES(SYNC), .CNT_W(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .slow_clk(slow_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_tgl(req_tgl), .tx_data(tx_data), .ack_tgl(ack_tgl),
    .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
`ifdef SYN_TX_TIMEOUT_EN
    , .err(err), .err_flag(err_flag)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transfer in flight, toggle parity, counters, ack seen SYNC edges late.
  logic       m_req, m_busy, m_done, m_err, m_errf, m_acc;
  logic [3:0] m_data;
  logic [7:0] m_cnt;
  int         m_wait;
  logic       hist[$];
  logic [3:0] sent[$];

  function automatic logic m_ready();
    return !m_busy && (hist[SYNC-1] == m_req);
  endfunction

  task automatic model_clear();
    m_req = 0; m_busy = 0; m_done = 0; m_err = 0; m_errf = 0;
    m_data = 0; m_cnt = 0; m_wait = 0; m_acc = 0;
    hist.delete();
    for (int i = 0; i < int'(SYNC); i++) hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] d, input logic a);
    logic as;
    if (r) begin
      model_clear();
      sent.delete();
      return;
    end
    as     = hist[SYNC-1];
    m_done = 0;
    m_err  = 0;
    m_acc  = 0;
    if (!m_busy) begin
      if (v && as == m_req) begin
        m_data = d; m_req = ~m_req; m_busy = 1; m_wait = 0; m_acc = 1;
        sent.push_back(d);
      end
    end else if (as == m_req) begin
      m_done = 1; m_busy = 0; m_cnt = m_cnt + 8'd1;
    end
`ifdef SYN_TX_TIMEOUT_EN
    else if (m_wait + 1 == int'(TMO)) begin
      m_err = 1; m_errf = 1; m_busy = 0;
    end else begin
      m_wait++;
    end
`endif
    hist.push_front(a);
    void'(hist.pop_back());
  endtask

  // Far-side receiver: detects req edges, checks the word, answers after a delay.
  logic rx_en, rx_req, rx_pend, rx_rand;
  int   rx_cnt, rx_fixed;

  task automatic rx_step();
    if (!rx_en) return;
    if (req_tgl !== rx_req) begin
      rx_req = req_tgl;
      if (sent.size() > 0) chk("rx_word", 32'(tx_data), 32'(sent.pop_front()));
      else chk("rx_unexpected_req", 32'(1), 32'(0));
      rx_cnt  = rx_rand ? int'($urandom_range(0, 6)) : rx_fixed;
      rx_pend = 1;
    end else if (rx_pend) begin
      if (rx_cnt == 0) begin
        ack_tgl = rx_req;
        rx_pend = 0;
      end else begin
        rx_cnt--;
      end
    end
  endtask

  // One clock: drive at negedge, step the model at posedge, compare 1 ns later.
  task automatic cycle(input logic r, input logic v, input logic [3:0] d);
    if (r) begin
      rx_req = 0; rx_pend = 0; ack_tgl = 0;
    end else begin
      rx_step();
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
    end
    rst = r; in_valid = v; in_data = d;
    @(posedge slow_clk);
    model_step(r, v, d, ack_tgl);
    #1;
    chk("req_tgl",  32'(req_tgl),  32'(m_req));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("done",     32'(done),     32'(m_done));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`ifdef SYN_TX_TIMEOUT_EN
    chk("err",      32'(err),      32'(m_err));
    chk("err_flag", 32'(err_flag), 32'(m_errf));
`endif
    @(negedge slow_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0);
  endtask

  // Offers words with in_valid held high; each word advances only when accepted.
  task automatic stream(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
    logic [3:0] q[$];
    int budget;
    q.push_back(w0); q.push_back(w1); q.push_back(w2);
    budget = 200;
    while (q.size() > 0 && budget > 0) begin
      cycle(1'b0, 1'b1, q[0]);
      if (m_acc) void'(q.pop_front());
      budget--;
    end
    if (q.size() > 0) chk("stream_timeout", 32'(q.size()), 32'(0));
  endtask

  int cnt0;

  initial begin
    rst = 1; in_valid = 0; in_data = 0; ack_tgl = 0;
    rx_en = 1; rx_req = 0; rx_pend = 0; rx_rand = 0; rx_cnt = 0; rx_fixed = 5;
    model_clear();
    @(negedge slow_clk);

    // Reset, then idle with in_valid low.
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 4'h5);
    idle(2);
    chk("reset_in_ready", 32'(in_ready), 32'(1));

    // Single word 4'hA, ack after ~5 cycles.
    cycle(1'b0, 1'b1, 4'hA);
    chk("A_req_flipped", 32'(req_tgl), 32'(1));
    idle(14);
    chk("A_cnt", 32'(xfer_cnt), 32'(1));

    // Stream 1,2,3 with in_valid held high.
    rx_fixed = 2;
    cnt0 = int'(m_cnt);
    stream(4'h1, 4'h2, 4'h3);
    idle(10);
    chk("stream_cnt", 32'(xfer_cnt), 32'(cnt0 + 3));

    // Spurious ack edge while idle: in_ready drops, no done.
    rx_en = 0;
    cnt0 = int'(m_cnt);
    ack_tgl = ~ack_tgl;
    idle(5);
    chk("spur_in_ready", 32'(in_ready), 32'(0));
    ack_tgl = ~ack_tgl;
    idle(5);
    chk("spur_cnt", 32'(xfer_cnt), 32'(cnt0));
    rx_req = req_tgl;
    rx_en = 1;

    // Reset during WAIT_ACK; a later ack must not complete anything.
    rx_en = 0;
    cycle(1'b0, 1'b1, 4'h7);
    idle(1);
    cycle(1'b1, 1'b0, 4'h0);
    chk("rst_req", 32'(req_tgl), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    idle(2);
    ack_tgl = 1;
    idle(6);
    ack_tgl = 0;
    idle(4);
    rx_en = 1;

`ifdef SYN_TX_TIMEOUT_EN
    // Ack withheld: timeout error, then late ack, then a normal transfer.
    rx_en = 0;
    cycle(1'b0, 1'b1, 4'hC);
    idle(10);
    chk("tmo_flag", 32'(err_flag), 32'(1));
    chk("tmo_in_ready", 32'(in_ready), 32'(0));
    ack_tgl = req_tgl;
    rx_req = req_tgl;
    void'(sent.pop_front());
    idle(4);
    rx_en = 1;
    cnt0 = int'(m_cnt);
    cycle(1'b0, 1'b1, 4'hD);
    idle(12);
    chk("tmo_recover_cnt", 32'(xfer_cnt), 32'(cnt0 + 1));
`endif

    // Random traffic with random far-side latency and occasional resets.
    rx_rand = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) cycle(1'b1, 1'($urandom), 4'($urandom));
      else cycle(1'b0, 1'($urandom), 4'($urandom));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
